// File: rtl/store_commit_buffer_if.sv
// Commit-stage enqueue, cache store port and load-hazard query for store_commit_buffer.
interface store_commit_buffer_if #(
  parameter int unsigned DEPTH = 8
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic             enq_valid_i;
  logic             enq_ready_o;
  logic [31:0]      enq_addr_i;
  logic [1:0]       enq_size_i;
  logic [31:0]      enq_data_i;
  logic             enq_misaligned_o;
  logic [29:0]      store_address_o;
  logic [31:0]      store_data_o;
  logic [3:0]       store_bm_o;
  logic             store_valid_o;
  logic             cache_done_i;
  logic [31:0]      ld_addr_i;
  logic [1:0]       ld_size_i;
  logic             ld_hazard_o;
  logic             empty_o;
  logic [PTR_W:0]   count_o;

  modport master (
    output enq_valid_i, enq_addr_i, enq_size_i, enq_data_i, cache_done_i, ld_addr_i, ld_size_i,
    input  enq_ready_o, enq_misaligned_o, store_address_o, store_data_o, store_bm_o,
           store_valid_o, ld_hazard_o, empty_o, count_o
  );

  modport slave (
    input  enq_valid_i, enq_addr_i, enq_size_i, enq_data_i, cache_done_i, ld_addr_i, ld_size_i,
    output enq_ready_o, enq_misaligned_o, store_address_o, store_data_o, store_bm_o,
           store_valid_o, ld_hazard_o, empty_o, count_o
  );
endinterface

// File: rtl/store_commit_buffer.sv
// FIFO of retired stores feeding the dcache store port, with byte-lane alignment
// and a load-overlap hazard check against every buffered entry.
module store_commit_buffer #(
  parameter int unsigned DEPTH = 8
) (
  input logic                 cpu_clock_i,
  input logic                 cpu_reset_i,
  store_commit_buffer_if.slave bus
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic        valid;
    logic [29:0] addr;
    logic [31:0] data;
    logic [3:0]  bm;
  } entry_t;

  entry_t           ent_q [DEPTH];
  entry_t           ent_d [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             misaligned_q, misaligned_d;

  logic             full_c;
  logic             legal_c;
  logic             enq_fire_c;
  logic             deq_c;
  logic [3:0]       ld_mask_c;
  logic             hazard_c;

  // Byte mask for a size/offset pair; reserved size covers the whole word.
  function automatic logic [3:0] mask_of(input logic [1:0] size, input logic [1:0] off);
    case (size)
      2'b00:   return 4'b0001 << off;
      2'b01:   return 4'b0011 << off;
      default: return 4'b1111;
    endcase
  endfunction

  always_comb begin
    full_c     = (count_q == CNT_W'(DEPTH));
    legal_c    = (bus.enq_size_i == 2'b00) ||
                 (bus.enq_size_i == 2'b01 && !bus.enq_addr_i[0]) ||
                 (bus.enq_size_i == 2'b10 && bus.enq_addr_i[1:0] == 2'b00);
    enq_fire_c = bus.enq_valid_i && !full_c && legal_c;
    deq_c      = bus.cache_done_i && (count_q != '0);

    for (int i = 0; i < DEPTH; i++) ent_d[i] = ent_q[i];
    head_d       = head_q;
    tail_d       = tail_q;
    misaligned_d = bus.enq_valid_i && !full_c && !legal_c;

    if (enq_fire_c) begin
      ent_d[tail_q].valid = 1'b1;
      ent_d[tail_q].addr  = bus.enq_addr_i[31:2];
      ent_d[tail_q].data  = bus.enq_data_i << {bus.enq_addr_i[1:0], 3'b000};
      ent_d[tail_q].bm    = mask_of(bus.enq_size_i, bus.enq_addr_i[1:0]);
      tail_d              = tail_q + PTR_W'(1);
    end
    // Head and tail never coincide here unless count is 0 (no deq) or full (no enq).
    if (deq_c) begin
      ent_d[head_q].valid = 1'b0;
      head_d              = head_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(enq_fire_c) - CNT_W'(deq_c);
  end

  // Hazard looks only at registered entries, so same-cycle enqueues are excluded.
  always_comb begin
    ld_mask_c = mask_of(bus.ld_size_i, bus.ld_addr_i[1:0]);
    hazard_c  = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (ent_q[i].valid && ent_q[i].addr == bus.ld_addr_i[31:2] && |(ent_q[i].bm & ld_mask_c))
        hazard_c = 1'b1;
    end
  end

  always_ff @(posedge cpu_clock_i) begin
    if (cpu_reset_i) begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      head_q       <= '0;
      tail_q       <= '0;
      count_q      <= '0;
      misaligned_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) ent_q[i] <= ent_d[i];
      head_q       <= head_d;
      tail_q       <= tail_d;
      count_q      <= count_d;
      misaligned_q <= misaligned_d;
    end
  end

  assign bus.enq_ready_o      = !full_c;
  assign bus.enq_misaligned_o = misaligned_q;
  assign bus.store_address_o  = ent_q[head_q].addr;
  assign bus.store_data_o     = ent_q[head_q].data;
  assign bus.store_bm_o       = ent_q[head_q].bm;
  assign bus.store_valid_o    = (count_q != '0);
  assign bus.ld_hazard_o      = hazard_c;
  assign bus.empty_o          = (count_q == '0);
  assign bus.count_o          = count_q;
endmodule

// File: tb/tb_store_commit_buffer.sv
// Directed self-checking bench for store_commit_buffer.
module tb_store_commit_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  store_commit_buffer_if #(.DEPTH(8)) bus ();

  store_commit_buffer #(.DEPTH(8)) dut (
    .cpu_clock_i (clk),
    .cpu_reset_i (rst),
    .bus         (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] data);
    bus.enq_valid_i = 1'b1;
    bus.enq_addr_i  = addr;
    bus.enq_size_i  = size;
    bus.enq_data_i  = data;
    tick();
    bus.enq_valid_i = 1'b0;
  endtask

  task automatic done_pulse();
    bus.cache_done_i = 1'b1;
    tick();
    bus.cache_done_i = 1'b0;
  endtask

  initial begin
    bus.enq_valid_i  = 1'b0;
    bus.enq_addr_i   = '0;
    bus.enq_size_i   = '0;
    bus.enq_data_i   = '0;
    bus.cache_done_i = 1'b0;
    bus.ld_addr_i    = '0;
    bus.ld_size_i    = 2'b10;

    // Reset state
    tick(); tick();
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(bus.store_valid_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_ready", 32'(bus.enq_ready_o), 32'd1);
    check("rst_count", 32'(bus.count_o), 32'd0);
    check("rst_hazard", 32'(bus.ld_hazard_o), 32'd0);
    check("rst_misal", 32'(bus.enq_misaligned_o), 32'd0);

    // Byte store at 0x1003
    enq(32'h0000_1003, 2'b00, 32'h0000_00AB);
    check("b_valid", 32'(bus.store_valid_o), 32'd1);
    check("b_addr", 32'(bus.store_address_o), 32'h0000_0400);
    check("b_bm", 32'(bus.store_bm_o), 32'h8);
    check("b_data", bus.store_data_o, 32'hAB00_0000);
    done_pulse();
    check("b_drained_valid", 32'(bus.store_valid_o), 32'd0);
    check("b_drained_empty", 32'(bus.empty_o), 32'd1);

    // Half store then misaligned word
    enq(32'h0000_2002, 2'b01, 32'h0000_1234);
    check("h_bm", 32'(bus.store_bm_o), 32'hC);
    check("h_data", bus.store_data_o, 32'h1234_0000);
    enq(32'h0000_3001, 2'b10, 32'hFFFF_FFFF);
    check("mis_pulse", 32'(bus.enq_misaligned_o), 32'd1);
    check("mis_count", 32'(bus.count_o), 32'd1);
    tick();
    check("mis_pulse_end", 32'(bus.enq_misaligned_o), 32'd0);
    enq(32'h0000_3000, 2'b11, 32'h0);
    check("size11_pulse", 32'(bus.enq_misaligned_o), 32'd1);
    check("size11_count", 32'(bus.count_o), 32'd1);
    done_pulse();
    check("h_empty", 32'(bus.empty_o), 32'd1);

    // Fill to full
    for (int i = 0; i < 8; i++) enq(32'h0000_5000 + 32'(4 * i), 2'b10, 32'h1000 + 32'(i));
    check("full_ready", 32'(bus.enq_ready_o), 32'd0);
    check("full_count", 32'(bus.count_o), 32'd8);
    enq(32'h0000_7000, 2'b10, 32'hDEAD);
    check("full_reject_count", 32'(bus.count_o), 32'd8);
    check("full_head_data", bus.store_data_o, 32'h1000);
    check("full_head_addr", 32'(bus.store_address_o), 32'h1400);
    // Done while full with a store offered: no pass-through
    bus.enq_valid_i  = 1'b1;
    bus.enq_addr_i   = 32'h0000_7000;
    bus.enq_data_i   = 32'hDEAD;
    bus.cache_done_i = 1'b1;
    tick();
    bus.enq_valid_i  = 1'b0;
    bus.cache_done_i = 1'b0;
    check("full_deq_count", 32'(bus.count_o), 32'd7);
    check("full_deq_ready", 32'(bus.enq_ready_o), 32'd1);
    check("full_deq_head", bus.store_data_o, 32'h1001);
    for (int i = 1; i < 8; i++) begin
      check("full_drain_data", bus.store_data_o, 32'h1000 + 32'(i));
      done_pulse();
    end
    check("full_drain_empty", 32'(bus.empty_o), 32'd1);

    // Streaming enq + done every cycle across pointer wrap
    enq(32'h0000_8000, 2'b10, 32'h100);
    for (int k = 0; k < 20; k++) begin
      check("stream_head", bus.store_data_o, 32'h100 + 32'(k));
      bus.enq_valid_i  = 1'b1;
      bus.enq_addr_i   = 32'h0000_8000 + 32'(4 * (k + 1));
      bus.enq_size_i   = 2'b10;
      bus.enq_data_i   = 32'h101 + 32'(k);
      bus.cache_done_i = 1'b1;
      tick();
      bus.enq_valid_i  = 1'b0;
      bus.cache_done_i = 1'b0;
      check("stream_count", 32'(bus.count_o), 32'd1);
    end
    check("stream_last", bus.store_data_o, 32'h114);
    done_pulse();
    check("stream_empty", 32'(bus.empty_o), 32'd1);

    // Load hazard
    bus.ld_addr_i   = 32'h0000_4000;
    bus.ld_size_i   = 2'b01;
    bus.enq_valid_i = 1'b1;
    bus.enq_addr_i  = 32'h0000_4001;
    bus.enq_size_i  = 2'b00;
    bus.enq_data_i  = 32'h55;
    #1;
    check("hz_same_cycle", 32'(bus.ld_hazard_o), 32'd0);
    tick();
    bus.enq_valid_i = 1'b0;
    check("hz_half_4000", 32'(bus.ld_hazard_o), 32'd1);
    bus.ld_addr_i = 32'h0000_4002; bus.ld_size_i = 2'b00; #1;
    check("hz_byte_4002", 32'(bus.ld_hazard_o), 32'd0);
    bus.ld_addr_i = 32'h0000_4004; bus.ld_size_i = 2'b10; #1;
    check("hz_word_4004", 32'(bus.ld_hazard_o), 32'd0);
    bus.ld_addr_i = 32'h0000_4003; bus.ld_size_i = 2'b11; #1;
    check("hz_size11", 32'(bus.ld_hazard_o), 32'd1);
    bus.ld_addr_i = 32'h0000_4000; bus.ld_size_i = 2'b01;
    bus.cache_done_i = 1'b1; #1;
    check("hz_inflight", 32'(bus.ld_hazard_o), 32'd1);
    tick();
    bus.cache_done_i = 1'b0;
    check("hz_after_done", 32'(bus.ld_hazard_o), 32'd0);

    // Reset with 3 entries and head in flight
    for (int i = 0; i < 3; i++) enq(32'h0000_6000 + 32'(4 * i), 2'b10, 32'h600 + 32'(i));
    check("pre_rst_count", 32'(bus.count_o), 32'd3);
    bus.ld_addr_i = 32'h0000_6000; bus.ld_size_i = 2'b10;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_count", 32'(bus.count_o), 32'd0);
    check("mid_rst_valid", 32'(bus.store_valid_o), 32'd0);
    check("mid_rst_hazard", 32'(bus.ld_hazard_o), 32'd0);
    done_pulse();
    check("late_done_count", 32'(bus.count_o), 32'd0);
    check("late_done_valid", 32'(bus.store_valid_o), 32'd0);
    check("late_done_ready", 32'(bus.enq_ready_o), 32'd1);
    // Fresh store after reset lands at entry 0 as new head
    enq(32'h0000_9000, 2'b10, 32'h9999);
    check("post_rst_head", bus.store_data_o, 32'h9999);
    check("post_rst_count", 32'(bus.count_o), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
